// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with a clock-enable prescaler and a
// time-multiplexed 7-segment scanner (shared active-low segment bus plus
// one active-low anode per digit). There is no derived clock; everything
// runs on clk.

// One BCD digit: its state, its carry/borrow link, its leading-zero link
// and its own segment pattern. The top keeps one of these per digit.
module bcd_digit #(
  parameter bit LSD      = 1'b0,  // least significant digit, never blanked
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,       // synchronous clear, beats any step
  input  logic       up,        // 1 = increment, 0 = decrement
  input  logic       cin,       // step request (carry/borrow from below)
  input  logic       nz_above,  // some more significant digit is non-zero
  output logic [3:0] dig,
  output logic       cout,      // step request for the next digit up
  output logic       nz_out,    // this digit or any above it is non-zero
  output logic [6:0] seg        // active-low g..a, already blanked
);

  logic [3:0] dig_q, dig_d;
  logic       at_lim;

  // Next digit value: clear first, otherwise step with wrap at 9/0.
  always_comb begin
    at_lim = up ? (dig_q == 4'd9) : (dig_q == 4'd0);
    cout   = cin & at_lim;
    dig_d  = dig_q;
    if (clr) begin
      dig_d = 4'd0;
    end else if (cin) begin
      if (up) dig_d = at_lim ? 4'd0 : dig_q + 4'd1;
      else    dig_d = at_lim ? 4'd9 : dig_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dig_q <= 4'd0;
    else     dig_q <= dig_d;
  end

  assign dig    = dig_q;
  assign nz_out = nz_above | (dig_q != 4'd0);

  // Segment decode, with leading-zero blanking on the upper digits.
  always_comb begin
    case (dig_q)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    if (BLANK_LZ && !LSD && !nz_out) seg = 7'b1111111;
  end

endmodule

module bcd_counter_display #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000000,
  parameter int REFRESH  = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  upDown,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic [6:0]            seg7,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW = (REFRESH  > 1) ? $clog2(REFRESH)  : 1;
  localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [DIGITS:0]             cy;     // cy[i] = step request into digit i
  logic [DIGITS:0]             nz;     // nz[i] = digit i or above non-zero
  logic [DIGITS-1:0][3:0]      digs;
  logic [DIGITS-1:0][6:0]      segs;
  logic [DIGITS-1:0]           an_sel;

  // Prescaler wraps at PRESCALE-1; tick is registered so it is low during
  // reset and is high exactly while the prescaler sits at its last value.
  always_comb begin
    pre_d  = (pre_q == PW'(PRESCALE - 1)) ? '0 : pre_q + PW'(1);
    tick_d = (pre_d == PW'(PRESCALE - 1));
  end

  // Scan timing: hold each digit REFRESH cycles, then move to the next.
  always_comb begin
    ref_d = ref_q;
    idx_d = idx_q;
    if (ref_q == RW'(REFRESH - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      ref_d = ref_q + RW'(1);
    end
  end

  // Prescaler and scanner state; neither is touched by clear or enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      ref_q  <= '0;
      idx_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      ref_q  <= ref_d;
      idx_q  <= idx_d;
    end
  end

  assign cy[0]      = tick_q & enable;
  assign nz[DIGITS] = 1'b0;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit #(
      .LSD      (i == 0),
      .BLANK_LZ (BLANK_LZ)
    ) u_dig (
      .clk      (clk),
      .rst      (rst),
      .clr      (clear),
      .up       (upDown),
      .cin      (cy[i]),
      .nz_above (nz[i+1]),
      .dig      (digs[i]),
      .cout     (cy[i+1]),
      .nz_out   (nz[i]),
      .seg      (segs[i])
    );
  end

  // Final carry out and the whole-number non-zero flag have no consumer.
  logic unused_chain;
  assign unused_chain = cy[DIGITS] | nz[0];

  // One-hot active-low anode for the selected digit.
  always_comb begin
    an_sel        = '1;
    an_sel[idx_q] = 1'b0;
  end

  assign count = digs;
  assign tick  = tick_q;
  assign an    = an_sel;
  assign seg7  = segs[idx_q];

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
Parametrised successor to the single-digit counter/7-segment top. Multi-digit decimal (BCD) up/down counter with a built-in clock-enable prescaler, so there is no derived clock. It also contains a time-multiplexed 7-segment scanner that drives one shared segment bus plus per-digit anode selects. It sits at board top level between the switches/buttons and the display.

Parameters:
DIGITS, 4, number of BCD digits counted and displayed (1..8)
PRESCALE, 50000000, clk cycles per count tick (>=1; 1 = tick every cycle)
REFRESH, 100000, clk cycles each digit stays selected during scanning (>=1)
BLANK_LZ, 1, 1 = blank leading zero digits; digit 0 is never blanked

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  count enable, sampled on prescaler tick
upDown  in  1  1 = count up, 0 = count down
clear  in  1  synchronous clear of count value
count  out  4*DIGITS  BCD value, digit i at [4i+3:4i], digit 0 least significant (debug/testbench)
tick  out  1  one-cycle prescaler strobe (debug)
seg7  out  7  active-low segments, bit0=a … bit6=g, for the currently selected digit
an  out  DIGITS  active-low one-hot digit select

Behaviour:
- Reset (async, rst=1): prescaler=0, refresh counter=0, digit index=0, count=0, tick=0, an = all ones except an[0]=0, seg7=7'b1000000 ("0"). Holds while rst=1; takes effect immediately mid-operation.
- Prescaler: free-running 0..PRESCALE-1, independent of enable/clear. tick=1 for exactly the one cycle the prescaler equals PRESCALE-1, then it wraps to 0. With PRESCALE=1, tick=1 every cycle after reset release.
- Count update on rising edge, priority high to low:
  - clear=1 -> count=0, regardless of tick or enable.
  - tick=1 and enable=1 -> step by one.
  - otherwise hold.
- Up step: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. All-9s wraps to all-0s with no flag.
- Down step: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit. All-0s wraps to all-9s.
- Each digit always holds 0..9; no non-BCD value is ever produced.
- Scanner:
  - Refresh counter runs 0..REFRESH-1.
  - On its terminal value, the digit index advances by one, wrapping DIGITS-1 -> 0. With DIGITS=1 the index stays 0.
  - an[idx]=0, all other an bits=1.
- seg7 is a combinational decode of the digit selected by the current idx, so an and seg7 are always consistent in the same cycle. Count changes are reflected on the next cycle without waiting for a rescan.
- Decode, active-low, g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Blanking (BLANK_LZ=1): a digit k>0 is blanked when it and all digits above it are 0. A blanked digit drives seg7=7'b1111111 while its anode is still selected. BLANK_LZ=0 shows all digits.
- Simultaneous events: the scan and prescaler are unaffected by clear. A tick on the same edge as clear is discarded. An upDown change takes effect at the next tick only.

Test Plan:
(DIGITS=4, PRESCALE=2, REFRESH=3, BLANK_LZ=1 unless stated)
1. Assert rst for 2 cycles, release; apply rst again mid-count at 0123 -> count=0000, an=1110, seg7=1000000 immediately; tick low until the second cycle after release.
2. Up count: enable=1, upDown=1, start 0009, one tick -> 0010. Preload by counting from 9999, one tick -> 0000.
3. Down count: from 0000, one tick -> 9999; from 0100, one tick -> 0099; enable=0 across 5 ticks -> value unchanged.
4. Clear coincident with tick at 0456 -> next cycle 0000, not 0455/0457; the prescaler phase continues unbroken.
5. Scan at count 0042: an cycles 1110,1101,1011,0111, each held 3 cycles, then wraps. seg7 = 2 (0100100), 4 (0011001), blank, blank. With BLANK_LZ=0, digits 2 and 3 show 1000000.
6. PRESCALE=1, DIGITS=2, up from 00 for 100 cycles -> tick every cycle, count wraps 99->00 and returns to 00.
